// File: rtl/tx_timer_pkg.sv
// Shared types and defaults for the TX bit/word/packet timer.
// The optional stuff-slot feature is enabled by defining TX_BIT_TIMER_STUFF_EN.
package tx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  localparam int unsigned DEF_BIT_CYCLES = 8;
  localparam int unsigned DEF_WORD_BITS  = 8;
  localparam int unsigned DEF_MAX_WORDS  = 64;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_CYC_W = cnt_w(DEF_BIT_CYCLES);
  localparam int unsigned DEF_BIT_W = cnt_w(DEF_WORD_BITS);
  localparam int unsigned DEF_WRD_W = cnt_w(DEF_MAX_WORDS);
  localparam int unsigned DEF_LEN_W = cnt_w(DEF_MAX_WORDS + 1);

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter 0..rollover_val with synchronous clear and enable.
// rollover_flag marks the enabled cycle in which the count wraps to zero.
module flex_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_top;

  assign at_top        = (count_q == rollover_val);
  assign rollover_flag = count_enable & at_top;
  assign count_out     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = at_top ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tx_bit_timer.sv
// Bit/word/packet timer for the TX serialiser: one shift_en strobe per bit period.
// Define TX_BIT_TIMER_STUFF_EN to add the stuff_req/stuff_slot bit-stuff insertion.
module tx_bit_timer
  import tx_timer_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned WORD_BITS  = DEF_WORD_BITS,
  parameter int unsigned MAX_WORDS  = DEF_MAX_WORDS
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                start,
  input  logic [cnt_w(MAX_WORDS + 1)-1:0]     word_count,
  input  logic                                pause,
  input  logic                                abort,
  output logic                                shift_en,
  output logic                                word_done,
  output logic                                packet_done,
  output logic                                busy,
  output logic [cnt_w(WORD_BITS)-1:0]         bit_idx,
  output logic [cnt_w(MAX_WORDS)-1:0]         word_idx,
`ifdef TX_BIT_TIMER_STUFF_EN
  input  logic                                stuff_req,
  output logic                                stuff_slot,
`endif
  output logic [1:0]                          dbg_state,
  output logic [cnt_w(BIT_CYCLES)-1:0]        dbg_cyc
);

  localparam int unsigned CYC_W = cnt_w(BIT_CYCLES);
  localparam int unsigned BIT_W = cnt_w(WORD_BITS);
  localparam int unsigned WRD_W = cnt_w(MAX_WORDS);
  localparam int unsigned LEN_W = cnt_w(MAX_WORDS + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_WORDS);

  tx_state_e        state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WRD_W-1:0] word_q, word_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [CYC_W-1:0] cyc;
  logic             cyc_roll;
  logic             cyc_en;
  logic             cyc_clr;
  logic             tick;
  logic             last_bit;
  logic             last_word;
  logic [LEN_W-1:0] wc_len;

  // The divider runs in RUN and STUFF alike; pause freezes it mid-period.
  assign cyc_en  = (state_q != IDLE) & ~pause;
  assign cyc_clr = abort | (state_q == IDLE);

  flex_counter #(
    .WIDTH (CYC_W)
  ) u_cyc (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cyc_clr),
    .count_enable  (cyc_en),
    .rollover_val  (CYC_LAST),
    .count_out     (cyc),
    .rollover_flag (cyc_roll)
  );

  assign tick      = (state_q == RUN) & cyc_roll & ~abort;
  assign last_bit  = (bit_q == BIT_LAST);
  assign last_word = (LEN_W'(word_q) == (len_q - LEN_W'(1)));
  assign wc_len    = (word_count > LEN_MAX) ? LEN_MAX : word_count;

  assign shift_en    = tick;
  assign word_done   = tick & last_bit;
  assign packet_done = tick & last_bit & last_word;
  assign busy        = (state_q != IDLE);
  assign bit_idx     = bit_q;
  assign word_idx    = word_q;
  assign dbg_state   = state_q;
  assign dbg_cyc     = cyc;
`ifdef TX_BIT_TIMER_STUFF_EN
  assign stuff_slot  = (state_q == STUFF);
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start && (word_count != '0)) begin
          state_d = RUN;
          len_d   = wc_len;
        end
      end
      RUN: begin
        if (tick) begin
          if (last_bit && last_word) begin
            state_d = IDLE;
            bit_d   = '0;
            word_d  = '0;
            len_d   = '0;
          end else begin
            if (last_bit) begin
              bit_d  = '0;
              word_d = word_q + WRD_W'(1);
            end else begin
              bit_d  = bit_q + BIT_W'(1);
            end
`ifdef TX_BIT_TIMER_STUFF_EN
            if (stuff_req) begin
              state_d = STUFF;
            end
`endif
          end
        end
      end
`ifdef TX_BIT_TIMER_STUFF_EN
      // One full inserted bit period; bit and word indices hold.
      STUFF: begin
        if (cyc_roll) begin
          state_d = RUN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      bit_d   = '0;
      word_d  = '0;
      len_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_tx_bit_timer.sv
// Randomized scoreboard bench for tx_bit_timer: expected shift events are queued
// by a timing model and popped by negedge monitors whenever shift_en fires.
module tb_tx_bit_timer;

  localparam int BC  = 8;
  localparam int WB  = 8;
  localparam int MW  = 64;
  localparam int BC2 = 2;
  localparam int WB2 = 4;
  localparam int EW  = 48;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] word_count = '0;
  logic       shift_en, word_done, packet_done, busy;
  logic [2:0] bit_idx;
  logic [5:0] word_idx;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cyc;

  logic       start2 = 1'b0;
  logic       pause2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [6:0] word_count2 = '0;
  logic       shift_en2, word_done2, packet_done2, busy2;
  logic [1:0] bit_idx2;
  logic [5:0] word_idx2;
  logic [1:0] dbg_state2;
  logic [0:0] dbg_cyc2;
`ifdef TX_BIT_TIMER_STUFF_EN
  logic       stuff_req = 1'b0;
  logic       stuff_slot, stuff_slot2;
`endif

  tx_bit_timer u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .word_count  (word_count),
    .pause       (pause),
    .abort       (abort),
    .shift_en    (shift_en),
    .word_done   (word_done),
    .packet_done (packet_done),
    .busy        (busy),
    .bit_idx     (bit_idx),
    .word_idx    (word_idx),
`ifdef TX_BIT_TIMER_STUFF_EN
    .stuff_req   (stuff_req),
    .stuff_slot  (stuff_slot),
`endif
    .dbg_state   (dbg_state),
    .dbg_cyc     (dbg_cyc)
  );

  tx_bit_timer #(
    .BIT_CYCLES (BC2),
    .WORD_BITS  (WB2),
    .MAX_WORDS  (MW)
  ) u_dut2 (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start2),
    .word_count  (word_count2),
    .pause       (pause2),
    .abort       (abort2),
    .shift_en    (shift_en2),
    .word_done   (word_done2),
    .packet_done (packet_done2),
    .busy        (busy2),
    .bit_idx     (bit_idx2),
    .word_idx    (word_idx2),
`ifdef TX_BIT_TIMER_STUFF_EN
    .stuff_req   (stuff_req),
    .stuff_slot  (stuff_slot2),
`endif
    .dbg_state   (dbg_state2),
    .dbg_cyc     (dbg_cyc2)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int wd_cnt = 0;
  int sh2_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];

  function automatic logic [EW-1:0] pk(input int t, input logic wd, input logic pd,
                                       input int b, input int w);
    return {32'(t), wd, pd, 6'(b), 8'(w)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc_cnt, got, exp);
    end
  endtask

  // Reference model: the n-th bit of a packet started at edge k ends at
  // k + n*bc - 1, pushed later by any pause that began at or before it and
  // discarded if an abort came first.
  task automatic push_pkt(input bit sel, input int k, input int wc, input int bc, input int wb,
                          input int p_rel, input int p_len, input int a_rel);
    int len;
    int t;
    len = (wc > MW) ? MW : wc;
    for (int n = 1; n <= len * wb; n++) begin
      t = k + n * bc - 1;
      if (p_rel >= 0 && t >= k + p_rel) t += p_len;
      if (a_rel >= 0 && t >= k + a_rel) continue;
      if (sel) exp2_q.push_back(pk(t, (n % wb) == 0, n == len * wb, (n - 1) % wb, (n - 1) / wb));
      else     exp_q.push_back(pk(t, (n % wb) == 0, n == len * wb, (n - 1) % wb, (n - 1) / wb));
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    if (n_rst) begin
      if (shift_en) begin
        if (word_done) wd_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_shift at cycle %0d: got shift_en=1 expected none", cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          g = pk(cyc_cnt, word_done, packet_done, int'(bit_idx), int'(word_idx));
          chk("shift_event", 64'(g), 64'(e));
        end
      end else if (word_done || packet_done) begin
        chk("strobe_without_shift", {62'd0, word_done, packet_done}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    if (n_rst && shift_en2) begin
      sh2_cnt++;
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shift2 at cycle %0d: got shift_en=1 expected none", cyc_cnt);
      end else begin
        e = exp2_q.pop_front();
        g = pk(cyc_cnt, word_done2, packet_done2, int'(bit_idx2), int'(word_idx2));
        chk("shift_event2", 64'(g), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_cycle(input int c);
    while (cyc_cnt < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle with busy low.
  task automatic run_pkt(input int wc, input int p_rel, input int p_len,
                         input int a_rel, input int ig_rel);
    int k;
    int len;
    int dur;
    int pl;
    pl  = (p_rel >= 0) ? p_len : 0;
    len = (wc > MW) ? MW : wc;
    start = 1'b1;
    word_count = 7'(wc);
    k = cyc_cnt + 1;
    push_pkt(1'b0, k, wc, BC, WB, p_rel, pl, a_rel);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_at_start", 64'(busy), 64'(len > 0));
    if (len == 0) begin
      at_cycle(k + 20);
      chk("idle_after_wc0", {busy, bit_idx, word_idx}, 64'd0);
    end else if (a_rel >= 0) begin
      at_cycle(k + a_rel);
      abort = 1'b1;
      at_cycle(k + a_rel + 1);
      abort = 1'b0;
      chk("idle_after_abort", {busy, bit_idx, word_idx}, 64'd0);
    end else begin
      if (p_rel >= 0) begin
        at_cycle(k + p_rel);
        pause = 1'b1;
        at_cycle(k + p_rel + p_len);
        pause = 1'b0;
      end
      if (ig_rel >= 0) begin
        at_cycle(k + ig_rel);
        start = 1'b1;
        word_count = 7'($urandom_range(1, 5));
        at_cycle(k + ig_rel + 1);
        start = 1'b0;
      end
      dur = len * WB * BC + pl;
      at_cycle(k + dur - 1);
      chk("busy_last_cycle", 64'(busy), 64'd1);
      at_cycle(k + dur);
      chk("idle_after_packet", {busy, bit_idx, word_idx}, 64'd0);
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int wc;
    int mode;
    int r;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {shift_en, word_done, packet_done, busy, bit_idx, word_idx, dbg_state},
        64'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Default two-word packet, then back-to-back repeat.
    run_pkt(2, -1, 0, -1, -1);
    run_pkt(2, -1, 0, -1, -1);

    // Asynchronous reset mid-packet.
    start = 1'b1;
    word_count = 7'd2;
    k = cyc_cnt + 1;
    push_pkt(1'b0, k, 2, BC, WB, -1, 0, -1);
    @(posedge clk);
    #1;
    start = 1'b0;
    at_cycle(k + 40);
    #3;
    n_rst = 1'b0;
    #1;
    chk("reset_mid_packet", {shift_en, word_done, packet_done, busy, bit_idx, word_idx, dbg_state},
        64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Five-cycle pause at cyc=3 of bit 2.
    run_pkt(2, 2 * BC + 3, 5, -1, -1);
    // Abort in word 1 bit 4, then a fresh packet in the next cycle.
    run_pkt(2, -1, 0, (WB + 4) * BC + 3, -1);
    run_pkt(2, -1, 0, -1, -1);
    // Length boundaries and ignored start.
    run_pkt(0, -1, 0, -1, -1);
    wd_cnt = 0;
    run_pkt(MW + 5, -1, 0, -1, -1);
    chk("word_done_count_clamped", 64'(wd_cnt), 64'(MW));
    run_pkt(2, -1, 0, -1, 30);

    // Randomized packets.
    for (int i = 0; i < 12; i++) begin
      wc = $urandom_range(1, 4);
      mode = $urandom_range(0, 3);
      case (mode)
        0: run_pkt(wc, -1, 0, -1, -1);
        1: run_pkt(wc, $urandom_range(0, wc * WB * BC - 1), $urandom_range(1, 6), -1, -1);
        2: begin
          r = $urandom_range(1, wc * WB * BC - 2);
          if (r % BC == BC - 1) r--;
          run_pkt(wc, -1, 0, r, -1);
        end
        default: run_pkt(wc, -1, 0, -1, $urandom_range(1, wc * WB * BC - 3));
      endcase
    end

    // Non-default geometry: 2 cycles/bit, 4 bits/word, 3 words.
    sh2_cnt = 0;
    start2 = 1'b1;
    word_count2 = 7'd3;
    k = cyc_cnt + 1;
    push_pkt(1'b1, k, 3, BC2, WB2, -1, 0, -1);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    at_cycle(k + 23);
    chk("busy2_last_cycle", 64'(busy2), 64'd1);
    at_cycle(k + 24);
    chk("idle2_after_packet", {busy2, bit_idx2, word_idx2}, 64'd0);
    chk("shift2_count", 64'(sh2_cnt), 64'd12);
    chk("queue2_drained", 64'(exp2_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got no completion, expected completion", cyc_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
